// File: rtl/game_pkg.sv
// Shared definitions for the keyboard front end: HID keycodes, action bit
// positions, decoder FSM states and the keycode-to-action decode.
package game_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StQualify,
    StHeld,
    StRepeat
  } key_state_e;

  localparam logic [7:0] KeyNone  = 8'h00;
  localparam logic [7:0] KeyUp    = 8'h1A;
  localparam logic [7:0] KeyDown  = 8'h16;
  localparam logic [7:0] KeyLeft  = 8'h04;
  localparam logic [7:0] KeyRight = 8'h07;
  localparam logic [7:0] KeyStart = 8'h28;
  localparam logic [7:0] KeyPause = 8'h2C;

  localparam int unsigned NumActions = 6;
  localparam int unsigned ActUp      = 0;
  localparam int unsigned ActDown    = 1;
  localparam int unsigned ActLeft    = 2;
  localparam int unsigned ActRight   = 3;
  localparam int unsigned ActStart   = 4;
  localparam int unsigned ActPause   = 5;

  // Unmapped keycodes decode to no action.
  function automatic logic [NumActions-1:0] decode_action(input logic [7:0] code);
    logic [NumActions-1:0] act;
    act = '0;
    case (code)
      KeyUp:    act[ActUp]    = 1'b1;
      KeyDown:  act[ActDown]  = 1'b1;
      KeyLeft:  act[ActLeft]  = 1'b1;
      KeyRight: act[ActRight] = 1'b1;
      KeyStart: act[ActStart] = 1'b1;
      KeyPause: act[ActPause] = 1'b1;
      default:  act = '0;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Brings the vsync level into the Clk domain and emits a one-cycle
// registered tick per rising edge of the synchronized level.
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic frame_tick
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic tick_q, tick_d;

  always_comb begin
    sync1_d = frame_clk;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    tick_d  = sync2_q & ~prev_q;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      tick_q  <= tick_d;
    end
  end

  assign frame_tick = tick_q;

endmodule

// File: rtl/key_event_decoder.sv
// Debounces the raw HID keycode on frame ticks and produces held levels,
// press/auto-repeat pulses, release pulses and a pause toggle.
module key_event_decoder
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = 2,
  parameter int unsigned REPEAT_DELAY    = 20,
  parameter int unsigned REPEAT_RATE     = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  frame_clk,
  input  logic [7:0]            keycode,
  output logic [7:0]            key_code,
  output logic                  key_valid,
  output logic [NumActions-1:0] action_held,
  output logic [NumActions-1:0] action_pulse,
  output logic                  release_pulse,
  output logic                  pause_toggle
);

  localparam int unsigned MaxA     = (DEBOUNCE_FRAMES > REPEAT_DELAY) ? DEBOUNCE_FRAMES
                                                                      : REPEAT_DELAY;
  localparam int unsigned MaxParam = (MaxA > REPEAT_RATE) ? MaxA : REPEAT_RATE;
  localparam int unsigned CntW     = $clog2(MaxParam + 1);

  localparam logic [CntW-1:0] DebLim = CntW'(DEBOUNCE_FRAMES);
  localparam logic [CntW-1:0] DlyLim = CntW'(REPEAT_DELAY);
  localparam logic [CntW-1:0] RateLim = CntW'(REPEAT_RATE);

  logic frame_tick;

  frame_tick_gen u_frame_tick_gen (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .frame_tick (frame_tick)
  );

  key_state_e            state_q, state_d;
  logic [7:0]            cand_q, cand_d;
  logic [CntW-1:0]       stable_cnt_q, stable_cnt_d;
  logic [CntW-1:0]       hold_cnt_q, hold_cnt_d;
  logic [CntW-1:0]       rate_cnt_q, rate_cnt_d;
  logic [7:0]            key_code_q, key_code_d;
  logic                  key_valid_q, key_valid_d;
  logic [NumActions-1:0] action_held_q, action_held_d;
  logic [NumActions-1:0] action_pulse_q, action_pulse_d;
  logic                  release_pulse_q, release_pulse_d;
  logic                  pause_toggle_q, pause_toggle_d;

  logic            start_cand;
  logic            accept;
  logic [CntW-1:0] stable_inc, hold_inc, rate_inc;

  always_comb begin
    state_d         = state_q;
    cand_d          = cand_q;
    stable_cnt_d    = stable_cnt_q;
    hold_cnt_d      = hold_cnt_q;
    rate_cnt_d      = rate_cnt_q;
    key_code_d      = key_code_q;
    key_valid_d     = key_valid_q;
    pause_toggle_d  = pause_toggle_q;
    action_pulse_d  = '0;
    release_pulse_d = 1'b0;
    start_cand      = 1'b0;
    accept          = 1'b0;

    stable_inc = (stable_cnt_q >= DebLim) ? stable_cnt_q : stable_cnt_q + CntW'(1);
    hold_inc   = (hold_cnt_q >= DlyLim) ? hold_cnt_q : hold_cnt_q + CntW'(1);
    rate_inc   = (rate_cnt_q >= RateLim) ? rate_cnt_q : rate_cnt_q + CntW'(1);

    if (frame_tick) begin
      case (state_q)
        StIdle: begin
          if (keycode != KeyNone) start_cand = 1'b1;
        end
        StQualify: begin
          if (keycode == KeyNone) begin
            state_d      = StIdle;
            stable_cnt_d = '0;
          end else if (keycode == cand_q) begin
            stable_cnt_d = stable_inc;
            if (stable_inc >= DebLim) accept = 1'b1;
          end else begin
            start_cand = 1'b1;
          end
        end
        StHeld, StRepeat: begin
          if (keycode != key_code_q) begin
            // Release always precedes any new candidate in the same tick.
            release_pulse_d = 1'b1;
            key_valid_d     = 1'b0;
            hold_cnt_d      = '0;
            rate_cnt_d      = '0;
            stable_cnt_d    = '0;
            state_d         = StIdle;
            if (keycode != KeyNone) start_cand = 1'b1;
          end else if (state_q == StHeld) begin
            hold_cnt_d = hold_inc;
            if (hold_inc >= DlyLim) begin
              state_d        = StRepeat;
              rate_cnt_d     = '0;
              action_pulse_d = decode_action(key_code_q);
            end
          end else begin
            hold_cnt_d = hold_inc;
            if (rate_inc >= RateLim) begin
              rate_cnt_d     = '0;
              action_pulse_d = decode_action(key_code_q);
            end else begin
              rate_cnt_d = rate_inc;
            end
          end
        end
        default: state_d = StIdle;
      endcase

      if (start_cand) begin
        cand_d       = keycode;
        stable_cnt_d = CntW'(1);
        if (DEBOUNCE_FRAMES <= 1) accept = 1'b1;
        else state_d = StQualify;
      end

      if (accept) begin
        state_d        = StHeld;
        key_code_d     = cand_d;
        key_valid_d    = 1'b1;
        hold_cnt_d     = '0;
        rate_cnt_d     = '0;
        action_pulse_d = decode_action(cand_d);
        if (cand_d == KeyPause) pause_toggle_d = ~pause_toggle_q;
      end
    end

    action_held_d = key_valid_d ? decode_action(key_code_d) : '0;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q         <= StIdle;
      cand_q          <= KeyNone;
      stable_cnt_q    <= '0;
      hold_cnt_q      <= '0;
      rate_cnt_q      <= '0;
      key_code_q      <= KeyNone;
      key_valid_q     <= 1'b0;
      action_held_q   <= '0;
      action_pulse_q  <= '0;
      release_pulse_q <= 1'b0;
      pause_toggle_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      cand_q          <= cand_d;
      stable_cnt_q    <= stable_cnt_d;
      hold_cnt_q      <= hold_cnt_d;
      rate_cnt_q      <= rate_cnt_d;
      key_code_q      <= key_code_d;
      key_valid_q     <= key_valid_d;
      action_held_q   <= action_held_d;
      action_pulse_q  <= action_pulse_d;
      release_pulse_q <= release_pulse_d;
      pause_toggle_q  <= pause_toggle_d;
    end
  end

  assign key_code      = key_code_q;
  assign key_valid     = key_valid_q;
  assign action_held   = action_held_q;
  assign action_pulse  = action_pulse_q;
  assign release_pulse = release_pulse_q;
  assign pause_toggle  = pause_toggle_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench: stimulus queues expected pulse events, a negedge monitor
// pops and compares each one the decoder emits.
module tb_key_event_decoder;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic [7:0] keycode;
  logic [7:0] key_code;
  logic       key_valid;
  logic [5:0] action_held;
  logic [5:0] action_pulse;
  logic       release_pulse;
  logic       pause_toggle;

  always #5 Clk = ~Clk;

  key_event_decoder dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .frame_clk     (frame_clk),
    .keycode       (keycode),
    .key_code      (key_code),
    .key_valid     (key_valid),
    .action_held   (action_held),
    .action_pulse  (action_pulse),
    .release_pulse (release_pulse),
    .pause_toggle  (pause_toggle)
  );

  typedef struct packed {
    logic [5:0] pulse;
    logic       rel;
    logic [7:0] code;
    logic       valid;
    logic [5:0] held;
    logic       ptog;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  right_pulses = 0;
  logic ptog = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic ev_t mk(input logic [5:0] pulse, input logic rel, input logic [7:0] code,
                             input logic valid, input logic [5:0] held, input logic pt);
    ev_t e;
    e = '{pulse: pulse, rel: rel, code: code, valid: valid, held: held, ptog: pt};
    return e;
  endfunction

  always @(negedge Clk) begin
    ev_t act_ev;
    ev_t req_ev;
    if (action_pulse != 6'd0 || release_pulse) begin
      act_ev = {action_pulse, release_pulse, key_code, key_valid, action_held, pause_toggle};
      if (action_pulse[3]) right_pulses++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event actual=%h required=none", act_ev);
      end else begin
        req_ev = exp_q.pop_front();
        chk("event", 32'(act_ev), 32'(req_ev));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic do_frame(input logic [7:0] kc);
    keycode   = kc;
    frame_clk = 1'b1;
    cyc(4);
    frame_clk = 1'b0;
    cyc(4);
  endtask

  task automatic frames(input logic [7:0] kc, input int n);
    for (int i = 0; i < n; i++) do_frame(kc);
  endtask

  task automatic chk_state(input string name, input logic [7:0] code, input logic valid,
                           input logic [5:0] held);
    chk(name, {16'd0, key_code, key_valid, action_held, 1'b0}, {16'd0, code, valid, held, 1'b0});
  endtask

  initial begin
    Reset     = 1'b0;
    frame_clk = 1'b0;
    keycode   = 8'h00;
    cyc(3);
    chk("reset_outputs", {8'd0, key_code, key_valid, action_held, action_pulse, release_pulse,
                          pause_toggle}, 32'd0);

    // Frames seen while in reset are ignored.
    frames(8'h1A, 2);
    chk("reset_ignores_frames", {31'd0, key_valid}, 32'd0);
    Reset = 1'b1;
    cyc(2);
    do_frame(8'h1A);
    chk("one_frame_no_accept", {31'd0, key_valid}, 32'd0);
    do_frame(8'h00);

    // Two frames of W accept it.
    exp_q.push_back(mk(6'b000001, 1'b0, 8'h1A, 1'b1, 6'b000001, ptog));
    frames(8'h1A, 2);
    chk_state("w_accepted", 8'h1A, 1'b1, 6'b000001);
    exp_q.push_back(mk(6'b000000, 1'b1, 8'h1A, 1'b0, 6'b000000, ptog));
    do_frame(8'h00);
    chk_state("w_released_keeps_code", 8'h1A, 1'b0, 6'b000000);

    // A single S frame never qualifies.
    do_frame(8'h16);
    do_frame(8'h00);
    chk_state("s_glitch_rejected", 8'h1A, 1'b0, 6'b000000);

    // D held 30 frames: accept, repeat at frame 22, then 26 and 30.
    for (int i = 0; i < 4; i++)
      exp_q.push_back(mk(6'b001000, 1'b0, 8'h07, 1'b1, 6'b001000, ptog));
    exp_q.push_back(mk(6'b000000, 1'b1, 8'h07, 1'b0, 6'b000000, ptog));
    frames(8'h07, 30);
    chk_state("d_held_30", 8'h07, 1'b1, 6'b001000);
    do_frame(8'h00);
    chk("d_pulse_count", 32'(right_pulses), 32'd4);

    // Three Space presses of 25 frames: toggles only on accept.
    for (int p = 0; p < 3; p++) begin
      ptog = ~ptog;
      exp_q.push_back(mk(6'b100000, 1'b0, 8'h2C, 1'b1, 6'b100000, ptog));
      exp_q.push_back(mk(6'b100000, 1'b0, 8'h2C, 1'b1, 6'b100000, ptog));
      exp_q.push_back(mk(6'b000000, 1'b1, 8'h2C, 1'b0, 6'b000000, ptog));
      frames(8'h2C, 25);
      do_frame(8'h00);
    end
    chk("pause_toggle_after_3", {31'd0, pause_toggle}, 32'd1);

    // A then straight to W: release, then W accepted on its second frame.
    exp_q.push_back(mk(6'b000100, 1'b0, 8'h04, 1'b1, 6'b000100, ptog));
    exp_q.push_back(mk(6'b000000, 1'b1, 8'h04, 1'b0, 6'b000000, ptog));
    exp_q.push_back(mk(6'b000001, 1'b0, 8'h1A, 1'b1, 6'b000001, ptog));
    frames(8'h04, 3);
    do_frame(8'h1A);
    chk_state("switch_in_qualify", 8'h04, 1'b0, 6'b000000);
    do_frame(8'h1A);
    chk_state("switch_accepted", 8'h1A, 1'b1, 6'b000001);
    exp_q.push_back(mk(6'b000000, 1'b1, 8'h1A, 1'b0, 6'b000000, ptog));
    do_frame(8'h00);

    // Unmapped key: accepted but no action bits.
    frames(8'h05, 2);
    chk_state("unmapped_accepted", 8'h05, 1'b1, 6'b000000);
    exp_q.push_back(mk(6'b000000, 1'b1, 8'h05, 1'b0, 6'b000000, ptog));
    do_frame(8'h00);

    // Reset during auto-repeat, key kept held.
    exp_q.push_back(mk(6'b000001, 1'b0, 8'h1A, 1'b1, 6'b000001, ptog));
    exp_q.push_back(mk(6'b000001, 1'b0, 8'h1A, 1'b1, 6'b000001, ptog));
    frames(8'h1A, 23);
    Reset = 1'b0;
    cyc(1);
    chk("reset_in_repeat", {8'd0, key_code, key_valid, action_held, action_pulse, release_pulse,
                            pause_toggle}, 32'd0);
    ptog = 1'b0;
    cyc(2);
    Reset = 1'b1;
    cyc(2);
    do_frame(8'h1A);
    chk_state("requalify_frame1", 8'h00, 1'b0, 6'b000000);
    exp_q.push_back(mk(6'b000001, 1'b0, 8'h1A, 1'b1, 6'b000001, ptog));
    do_frame(8'h1A);
    chk_state("requalify_frame2", 8'h1A, 1'b1, 6'b000001);
    exp_q.push_back(mk(6'b000000, 1'b1, 8'h1A, 1'b0, 6'b000000, ptog));
    do_frame(8'h00);

    cyc(10);
    chk("events_outstanding", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
